// File: rtl/float_struct.sv
// Shared types and constants for the binary32 normalize/round/pack back end.
package float_struct;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 25;
  localparam int unsigned GRS_W  = 3;
  localparam int unsigned WORD_W = MANT_W + GRS_W;
  localparam int unsigned IEXP_W = EXP_W + 2;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned LZC_W  = 5;
  localparam int unsigned RES_W  = 32;

  typedef enum logic [1:0] {
    FP_OK  = 2'b00,
    FP_NAN = 2'b01,
    FP_INF = 2'b10,
    FP_NUL = 2'b11
  } fp_state_t;

  localparam logic [RES_W-1:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] FP_EXP_MAX = 8'hFF;
  localparam int unsigned      FP_BIAS    = 127;

  // Inter-stage payload: word is {carry, hidden, frac[22:0], G, R, S}.
  typedef struct packed {
    logic                     sign;
    logic signed [IEXP_W-1:0] exp;
    logic [WORD_W-1:0]        mant;
    fp_state_t                exc;
  } fp_payload_t;

endpackage

// File: rtl/fp_normalize_pack_if.sv
// Operand/result handshake bundle between the adder core and the FPU result port.
interface fp_normalize_pack_if;
  import float_struct::*;

  logic              in_vld;
  logic              in_rdy;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic [GRS_W-1:0]  in_grs;
  logic [1:0]        in_exc;
  logic [RES_W-1:0]  result;
  logic [1:0]        state;
  logic              res_vld;
  logic              res_rdy;

  modport master (
    output in_vld, in_sign, in_exp, in_mant, in_grs, in_exc, res_rdy,
    input  in_rdy, result, state, res_vld
  );

  modport slave (
    input  in_vld, in_sign, in_exp, in_mant, in_grs, in_exc, res_rdy,
    output in_rdy, result, state, res_vld
  );
endinterface

// File: rtl/fp_lzc28.sv
// Combinational leading-zero counter over the 28-bit raw word; 28 when all zero.
module fp_lzc28
  import float_struct::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [LZC_W-1:0]  lzc_c
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    lzc_c = LZC_W'(WORD_W);
    for (int i = 0; i < WORD_W; i++) begin
      if (word_i[i]) lzc_c = LZC_W'(WORD_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_pack.sv
// Three-stage normalize / round / pack into binary32 with valid/ready flow control.
// FPU_ROUND_NEAREST_EN selects round-to-nearest-even; default build truncates.
module fp_normalize_pack
  import float_struct::*;
(
  input  logic                clk,
  input  logic                rst,
  fp_normalize_pack_if.slave  bus
);

  localparam logic signed [IEXP_W-1:0] EXP_ONE = IEXP_W'(1);
  localparam logic signed [IEXP_W-1:0] EXP_SAT = IEXP_W'(FP_EXP_MAX);
  localparam logic signed [IEXP_W-1:0] EXP_MIN = '0;

  logic                     adv_c;
  logic                     v1_q, v1_d, v2_q, v2_d, res_vld_q, res_vld_d;
  fp_payload_t              s1_q, s1_d, s2_q, s2_d;
  logic [RES_W-1:0]         result_q, result_d;
  fp_state_t                state_q, state_d;
  logic [LZC_W-1:0]         lzc_c, shl_c;
  logic signed [IEXP_W-1:0] exp_r_c;
  logic [FRAC_W-1:0]        frac_c;
  logic                     unused_c;

  // Whole pipe moves in lockstep; only a held result blocks it.
  assign adv_c       = ~res_vld_q | bus.res_rdy;
  assign bus.in_rdy  = adv_c;
  assign bus.result  = result_q;
  assign bus.state   = state_q;
  assign bus.res_vld = res_vld_q;

  fp_lzc28 u_lzc (
    .word_i (s1_q.mant),
    .lzc_c  (lzc_c)
  );

  // S1: capture the raw operand
  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    if (adv_c) begin
      v1_d      = bus.in_vld;
      s1_d.sign = bus.in_sign;
      s1_d.exp  = IEXP_W'(bus.in_exp);
      s1_d.mant = {bus.in_mant, bus.in_grs};
      s1_d.exc  = fp_state_t'(bus.in_exc);
    end
  end

  // S2: bring the hidden bit to position 26
  always_comb begin
    v2_d  = v2_q;
    s2_d  = s2_q;
    shl_c = lzc_c - LZC_W'(1);
    if (adv_c) begin
      v2_d = v1_q;
      s2_d = s1_q;
      if (s1_q.mant[WORD_W-1]) begin
        s2_d.mant = {1'b0, s1_q.mant[WORD_W-1:2], s1_q.mant[1] | s1_q.mant[0]};
        s2_d.exp  = s1_q.exp + EXP_ONE;
      end else if (s1_q.mant == '0) begin
        if (s1_q.exc == FP_OK) s2_d.exc = FP_NUL;
      end else begin
        s2_d.mant = s1_q.mant << shl_c;
        s2_d.exp  = s1_q.exp - $signed(IEXP_W'(shl_c));
      end
    end
  end

`ifdef FPU_ROUND_NEAREST_EN
  logic                inc_c;
  logic [FRAC_W+1:0]   rnd_c;

  // Round half to even on the 24-bit significand; carry-out bumps the exponent.
  always_comb begin
    inc_c   = s2_q.mant[2] & (s2_q.mant[1] | s2_q.mant[0] | s2_q.mant[3]);
    rnd_c   = {1'b0, s2_q.mant[26:3]} + (FRAC_W+2)'(inc_c);
    frac_c  = rnd_c[FRAC_W-1:0];
    exp_r_c = rnd_c[FRAC_W+1] ? s2_q.exp + EXP_ONE : s2_q.exp;
  end

  assign unused_c = ^{s2_q.mant[WORD_W-1], rnd_c[FRAC_W]};
`else
  always_comb begin
    frac_c  = s2_q.mant[25:3];
    exp_r_c = s2_q.exp;
  end

  assign unused_c = ^{s2_q.mant[WORD_W-1:26], s2_q.mant[2:0]};
`endif

  // S3: classify and pack
  always_comb begin
    res_vld_d = res_vld_q;
    result_d  = result_q;
    state_d   = state_q;
    if (adv_c) begin
      res_vld_d = v2_q;
      if (v2_q) begin
        if (s2_q.exc == FP_NAN) begin
          result_d = FP_QNAN;
          state_d  = FP_NAN;
        end else if (s2_q.exc == FP_INF || exp_r_c >= EXP_SAT) begin
          result_d = {s2_q.sign, FP_EXP_MAX, FRAC_W'(0)};
          state_d  = FP_INF;
        end else if (s2_q.exc == FP_NUL || s2_q.mant == '0 || exp_r_c <= EXP_MIN) begin
          result_d = {s2_q.sign, (RES_W-1)'(0)};
          state_d  = FP_NUL;
        end else begin
          result_d = {s2_q.sign, exp_r_c[EXP_W-1:0], frac_c};
          state_d  = FP_OK;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      res_vld_q <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      result_q  <= '0;
      state_q   <= FP_NUL;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      res_vld_q <= res_vld_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      result_q  <= result_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed self-checking bench for fp_normalize_pack (honours FPU_ROUND_NEAREST_EN).
module tb_fp_normalize_pack;
  import float_struct::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  fp_normalize_pack_if bus ();

  fp_normalize_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic sign, input logic [7:0] e,
                       input logic [24:0] m, input logic [2:0] g, input logic [1:0] x);
    bus.in_vld  = vld;
    bus.in_sign = sign;
    bus.in_exp  = e;
    bus.in_mant = m;
    bus.in_grs  = g;
    bus.in_exc  = x;
  endtask

  // One isolated transaction: checks the 3-cycle latency, the result word and the state.
  task automatic run_one(input string tag, input logic sign, input logic [7:0] e,
                         input logic [24:0] m, input logic [2:0] g, input logic [1:0] x,
                         input logic [31:0] want_res, input logic [1:0] want_st);
    bus.res_rdy = 1'b1;
    drive(1'b1, sign, e, m, g, x);
    #1;
    chk({tag, "_in_rdy"}, 32'(bus.in_rdy), 32'd1);
    tick();
    drive(1'b0, 1'b0, 8'd0, 25'd0, 3'd0, 2'd0);
    chk({tag, "_vld_c1"}, 32'(bus.res_vld), 32'd0);
    tick();
    chk({tag, "_vld_c2"}, 32'(bus.res_vld), 32'd0);
    tick();
    chk({tag, "_vld_c3"}, 32'(bus.res_vld), 32'd1);
    chk({tag, "_result"}, bus.result, want_res);
    chk({tag, "_state"}, 32'(bus.state), 32'(want_st));
    tick();
    chk({tag, "_vld_drop"}, 32'(bus.res_vld), 32'd0);
  endtask

  logic [31:0] exp_q [5];
  logic [31:0] prev_res;
  logic        prev_stall;
  logic        stalled;
  logic        do_acc;
  logic        do_take;
  int          sent;
  int          got;
  int          stall_cnt;
  int          stall_seen;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.res_rdy = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 25'd0, 3'd0, 2'd0);

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_res_vld", 32'(bus.res_vld), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd3);
    chk("rst_result", bus.result, 32'h0);
    tick();
    tick();
    rst = 1'b1;

    // Directed vectors
    run_one("one_plus_one", 1'b0, 8'd127, 25'h1000000, 3'b000, 2'b00, 32'h40000000, 2'b00);
    run_one("cancel",       1'b0, 8'd127, 25'h0000001, 3'b000, 2'b00, 32'h34000000, 2'b00);
`ifdef FPU_ROUND_NEAREST_EN
    run_one("round_up",     1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 2'b00, 32'h40000000, 2'b00);
    run_one("carry_sticky", 1'b0, 8'd127, 25'h1000001, 3'b001, 2'b00, 32'h40000001, 2'b00);
`else
    run_one("round_up",     1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 2'b00, 32'h3FFFFFFF, 2'b00);
    run_one("carry_sticky", 1'b0, 8'd127, 25'h1000001, 3'b001, 2'b00, 32'h40000000, 2'b00);
`endif
    run_one("carry_tie",    1'b0, 8'd127, 25'h1000001, 3'b000, 2'b00, 32'h40000000, 2'b00);
    run_one("neg_1p5",      1'b1, 8'd130, 25'h0C00000, 3'b000, 2'b00, 32'hC1400000, 2'b00);
    run_one("overflow",     1'b0, 8'd254, 25'h1000000, 3'b000, 2'b00, 32'h7F800000, 2'b10);
    run_one("exc_nan",      1'b1, 8'd127, 25'h1000000, 3'b000, 2'b01, 32'h7FC00000, 2'b01);
    run_one("exc_inf",      1'b1, 8'd10,  25'h0800000, 3'b000, 2'b10, 32'hFF800000, 2'b10);
    run_one("zero_mant",    1'b1, 8'd100, 25'h0000000, 3'b000, 2'b00, 32'h80000000, 2'b11);
    run_one("underflow",    1'b0, 8'd5,   25'h0000001, 3'b000, 2'b00, 32'h00000000, 2'b11);

    // Backpressure: 5 back-to-back inputs, sink stalls 4 cycles once output is valid
    for (int i = 0; i < 5; i++) exp_q[i] = {1'b0, 8'(121 + i), 23'h0};
    sent = 0;
    got = 0;
    stall_cnt = 0;
    stall_seen = 0;
    prev_stall = 1'b0;
    prev_res = '0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      if (sent < 5) drive(1'b1, 1'b0, 8'(120 + sent), 25'h1000000, 3'b000, 2'b00);
      else          drive(1'b0, 1'b0, 8'd0, 25'd0, 3'd0, 2'd0);
      bus.res_rdy = !(bus.res_vld && stall_cnt < 4);
      #1;
      stalled = bus.res_vld & ~bus.res_rdy;
      if (stalled) begin
        stall_cnt++;
        stall_seen++;
        chk("bp_in_rdy_stalled", 32'(bus.in_rdy), 32'd0);
        if (prev_stall) chk("bp_result_hold", bus.result, prev_res);
      end
      prev_stall = stalled;
      prev_res   = bus.result;
      do_acc  = bus.in_vld & bus.in_rdy;
      do_take = bus.res_vld & bus.res_rdy;
      if (do_take) begin
        chk("bp_order", bus.result, exp_q[got]);
        got++;
      end
      tick();
      if (do_acc) sent++;
    end
    chk("bp_delivered", 32'(got), 32'd5);
    chk("bp_stall_cycles", 32'(stall_seen), 32'd4);
    drive(1'b0, 1'b0, 8'd0, 25'd0, 3'd0, 2'd0);
    bus.res_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_no_dup", 32'(bus.res_vld), 32'd0);
      tick();
    end

    // Reset with results in flight
    bus.res_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'(127 + i), 25'h1000000, 3'b000, 2'b00);
      tick();
    end
    drive(1'b0, 1'b0, 8'd0, 25'd0, 3'd0, 2'd0);
    chk("pre_rst_vld", 32'(bus.res_vld), 32'd1);
    chk("pre_rst_result", bus.result, 32'h40000000);
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(bus.res_vld), 32'd0);
    chk("mid_rst_state", 32'(bus.state), 32'd3);
    chk("mid_rst_result", bus.result, 32'h0);
    #1 rst = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("post_rst_quiet", 32'(bus.res_vld), 32'd0);
      tick();
    end
    run_one("post_rst", 1'b0, 8'd127, 25'h1000000, 3'b000, 2'b00, 32'h40000000, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_normalize_pack.md
Name: fp_normalize_pack

Overview:
Back end of the single-precision FPU datapath. Consumes the raw sign/exponent/unnormalized mantissa sum produced by the adder's mantissa stage. Normalizes, rounds and packs it into an IEEE-754 binary32 word with a 2-bit result state. Three-stage pipeline with valid/ready flow control, sitting between the adder core and the FPU result port.

Parameters:
EXP_W, 8, biased exponent width (fixed for binary32; internal exponent math uses EXP_W+2 signed bits)
MANT_W, 25, raw mantissa width: bit 24 carry, bit 23 hidden, bits 22:0 fraction

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
in_vld  in  1  raw operand valid
in_rdy  out  1  block can accept; transfer when in_vld & in_rdy
in_sign  in  1  result sign
in_exp  in  8  biased exponent of aligned operands
in_mant  in  25  raw mantissa sum
in_grs  in  3  guard, round, sticky bits from alignment shift
in_exc  in  2  upstream exception: 00 OK, 01 NAN, 10 INF, 11 NUL
result  out  32  packed binary32
state  out  2  00 OK, 01 NAN, 10 INF, 11 NUL
res_vld  out  1  result valid
res_rdy  in  1  downstream accepts

Behaviour:
- Reset (rst low, async): all stage valid bits 0, res_vld=0, result=0, state=2'b11. Data registers may keep stale values.
- Pipeline advance: adv = ~res_vld | res_rdy. All stages shift together when adv=1. in_rdy = adv. Latency 3 cycles from accepted input to res_vld when unstalled. Throughput 1/cycle.
- Stall: with res_vld=1 and res_rdy=0, result, state and all stages hold. Bubbles are not compressed.
- S1: register the input. Compute the leading-zero count of the 28-bit word {in_mant, in_grs} using fp_lzc28.
- S2, normalize:
  - carry bit set: shift right 1 (shifted-out bit ORed into sticky), exp+1.
  - else: shift left by lzc-1 so the hidden bit lands at bit 26, exp-(lzc-1).
  - whole word zero: mark NUL.
- S3, round: round to nearest even. Increment when G & (R | S | LSB). Mantissa overflow after increment gives exp+1, fraction 0.
- S3, pack, in priority order:
  - in_exc NAN: 0x7FC00000, state NAN.
  - in_exc INF, or normalized exp >= 255: {sign, 8'hFF, 23'h0}, state INF.
  - in_exc NUL, zero mantissa, or exp <= 0 (no subnormals, flush-to-zero): {sign, 31'h0}, state NUL.
  - otherwise {sign, exp[7:0], frac[22:0]}, state OK.
- Reset mid-operation drops all in-flight results. No res_vld follows reset until new inputs are accepted.

Optional Feature:
FPU_ROUND_NEAREST_EN
- Defined: S3 applies round-to-nearest-even as above.
- Undefined: truncation. GRS bits are ignored after normalization, the increment logic is removed, and latency stays 3.

Decomposition:
- Package float_struct, add:
  - fp_state_t enum (OK/NAN/INF/NUL)
  - constants FP_QNAN=32'h7FC00000, FP_EXP_MAX=8'hFF, FP_BIAS=127
  - a packed struct for inter-stage payload (sign, exp[9:0] signed, mant[27:0], exc)
- One sub-module, fp_lzc28: combinational 28-bit leading-zero counter, 5-bit output, 28 for all-zero.

Test Plan:
- 1.0+1.0 raw: sign=0, exp=127, mant=25'h1000000, grs=0, exc=OK -> result 0x40000000, state OK, res_vld exactly 3 cycles after accept.
- Cancellation: exp=127, mant=25'h0000001, grs=0 -> 0x34000000, state OK.
- Rounding: exp=127, mant=25'h0FFFFFF, grs=3'b100:
  - with FPU_ROUND_NEAREST_EN -> 0x40000000
  - without -> 0x3FFFFFFF
- Overflow and specials:
  - exp=254, mant=25'h1000000 -> 0x7F800000, state INF.
  - exc=NAN -> 0x7FC00000, state NAN.
  - mant=0, sign=1 -> 0x80000000, state NUL.
- Backpressure: stream 5 back-to-back inputs, hold res_rdy=0 for 4 cycles -> result stable while stalled, in_rdy=0 while stalled, all 5 results delivered in order with none lost or duplicated.
- Reset: assert rst low with 2 results in flight -> res_vld=0, state=2'b11 immediately; no output until the next accepted input plus 3 cycles.
